// File: rtl/dmem_pkg.sv
// ----------------------------------------------------------------------------
// dmem_pkg
// Shared types and constants for the data-memory responder slice.
//   dmem_state_e     : responder FSM states (IDLE, BUSY, DONE), 2-bit encoding
//   DMEM_WORD_BYTES  : bytes per memory word
//   DMEM_WORD_BITS   : bits per memory word
//   DMEM_CNT_W       : width of the wait-state counter (covers 0..15)
//   is_misaligned()  : true when a byte address is not word aligned
// ----------------------------------------------------------------------------
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } dmem_state_e;

    localparam int DMEM_WORD_BYTES = 4;
    localparam int DMEM_WORD_BITS  = 8 * DMEM_WORD_BYTES;
    localparam int DMEM_CNT_W      = 4;

    function automatic logic is_misaligned(input logic [1:0] lo_bits);
        return (lo_bits != 2'b00);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// ----------------------------------------------------------------------------
// dmem_array
// Single-port synchronous word RAM with a registered read port.
// The storage itself is never reset; only the read-data register is.
// Ports:
//   i_clk    : clock, rising edge
//   i_rst    : asynchronous reset, active-low (clears o_rdata only)
//   i_re     : update the read register this edge
//   i_clr    : when reading, load zero instead of memory contents
//   i_we     : write i_wdata to word i_idx this edge
//   i_idx    : word index
//   i_wdata  : write data
//   o_rdata  : registered read data, held between reads
// ----------------------------------------------------------------------------
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_re,
    input  logic                      i_clr,
    input  logic                      i_we,
    input  logic [IDX_W-1:0]          i_idx,
    input  logic [DMEM_WORD_BITS-1:0] i_wdata,
    output logic [DMEM_WORD_BITS-1:0] o_rdata
);

    logic [DMEM_WORD_BITS-1:0] r_mem [DEPTH_WORDS];
    logic [DMEM_WORD_BITS-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_idx] <= i_wdata;
        end
    end

    // Read register keeps the last loaded word until the next read.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= i_clr ? '0 : r_mem[i_idx];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// ----------------------------------------------------------------------------
// dmem_responder
// EX/MEM data-memory responder: accepts a load/store request, waits
// WAIT_CYCLES extra cycles, performs the word access and pulses done.
// The pipeline is stalled while a request is presented and not yet done.
// Optional feature macro: DMEM_ALIGN_CHK_EN (adds misalign port and
// suppresses/zeroes accesses whose addr[1:0] != 0).
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous reset, active-low
//   DM_enable  : request valid
//   DM_write   : 1 = store, 0 = load
//   addr       : byte address
//   wdata      : store data
//   rdata      : load data, valid while done = 1, held otherwise
//   done       : one-cycle completion pulse
//   stall      : combinational pipeline hold
//   misalign   : (DMEM_ALIGN_CHK_EN only) misaligned access, during DONE
// ----------------------------------------------------------------------------
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        DM_enable,
    input  logic        DM_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done,
`ifdef DMEM_ALIGN_CHK_EN
    output logic        stall,
    output logic        misalign
`else
    output logic        stall
`endif
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [DMEM_CNT_W-1:0] WAIT_LAST =
        (WAIT_CYCLES == 0) ? '0 : DMEM_CNT_W'(WAIT_CYCLES - 1);

    dmem_state_e        r_state;
    logic [DMEM_CNT_W-1:0] r_cnt;
    logic               r_write;
    logic [IDX_W-1:0]   r_idx;
    logic [31:0]        r_wdata;

    logic               w_accept;
    logic               w_access;
    logic               w_live;
    logic               w_write;
    logic [IDX_W-1:0]   w_idx;
    logic [31:0]        w_wdata;
    logic               w_mis;
    logic               w_we;
    logic               w_re;

    assign w_accept = (r_state == IDLE) && DM_enable;

    // With zero wait states the access happens on the accept edge itself,
    // so it must use the live request rather than the (not yet loaded) latches.
    assign w_access = (w_accept && (WAIT_CYCLES == 0)) ||
                      ((r_state == BUSY) && (r_cnt == '0));
    assign w_live   = (r_state == IDLE);
    assign w_write  = w_live ? DM_write : r_write;
    assign w_idx    = w_live ? addr[IDX_W+1:2] : r_idx;
    assign w_wdata  = w_live ? wdata : r_wdata;

`ifdef DMEM_ALIGN_CHK_EN
    logic r_mis;
    logic w_unused_addr;
    assign w_mis         = w_live ? is_misaligned(addr[1:0]) : r_mis;
    assign w_unused_addr = ^addr[31:IDX_W+2];
`else
    logic w_unused_addr;
    assign w_mis         = 1'b0;
    assign w_unused_addr = ^{addr[31:IDX_W+2], addr[1:0]};
`endif

    // A misaligned access never writes and reads back zero.
    assign w_we = w_access && w_write && !w_mis;
    assign w_re = w_access && (!w_write || w_mis);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_write <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (DM_enable) begin
                        r_write <= DM_write;
                        r_idx   <= addr[IDX_W+1:2];
                        r_wdata <= wdata;
                        if (WAIT_CYCLES == 0) begin
                            r_state <= DONE;
                        end else begin
                            r_state <= BUSY;
                            r_cnt   <= WAIT_LAST;
                        end
                    end
                end
                BUSY: begin
                    if (r_cnt == '0) begin
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef DMEM_ALIGN_CHK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mis <= 1'b0;
        end else if (w_accept) begin
            r_mis <= is_misaligned(addr[1:0]);
        end
    end

    assign misalign = (r_state == DONE) && r_mis;
`endif

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_re    (w_re),
        .i_clr   (w_mis),
        .i_we    (w_we),
        .i_idx   (w_idx),
        .i_wdata (w_wdata),
        .o_rdata (rdata)
    );

    assign done  = (r_state == DONE);
    assign stall = DM_enable && (r_state != DONE);

endmodule

// File: tb/tb_dmem_responder.sv
// ----------------------------------------------------------------------------
// tb_dmem_responder
// Directed bench for dmem_responder. Three instances with independent
// request inputs cover WAIT_CYCLES = 1, 0 and 3. Inputs change on the
// falling edge; outputs are sampled on the falling edge or 1 time unit later.
// ----------------------------------------------------------------------------
module tb_dmem_responder;

    localparam int N_DUT = 3;

    logic        clk;
    logic        rst;
    logic        en  [N_DUT];
    logic        wr  [N_DUT];
    logic [31:0] ad  [N_DUT];
    logic [31:0] wd  [N_DUT];
    logic [31:0] rd  [N_DUT];
    logic        dn  [N_DUT];
    logic        st  [N_DUT];
    logic        mi  [N_DUT];

    int vecs;
    int errs;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .rst(rst), .DM_enable(en[0]), .DM_write(wr[0]),
        .addr(ad[0]), .wdata(wd[0]), .rdata(rd[0]), .done(dn[0]),
`ifdef DMEM_ALIGN_CHK_EN
        .stall(st[0]), .misalign(mi[0])
`else
        .stall(st[0])
`endif
    );

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst), .DM_enable(en[1]), .DM_write(wr[1]),
        .addr(ad[1]), .wdata(wd[1]), .rdata(rd[1]), .done(dn[1]),
`ifdef DMEM_ALIGN_CHK_EN
        .stall(st[1]), .misalign(mi[1])
`else
        .stall(st[1])
`endif
    );

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .rst(rst), .DM_enable(en[2]), .DM_write(wr[2]),
        .addr(ad[2]), .wdata(wd[2]), .rdata(rd[2]), .done(dn[2]),
`ifdef DMEM_ALIGN_CHK_EN
        .stall(st[2]), .misalign(mi[2])
`else
        .stall(st[2])
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One transaction on instance k. The request is held until done unless
    // drop is set, in which case it is withdrawn (and the inputs scrambled)
    // in the first cycle after acceptance.
    task automatic applyStimulus(input int k, input logic w, input logic [31:0] a,
                                 input logic [31:0] d, input logic drop, input int expLat,
                                 output logic [31:0] rdOut, output logic misOut);
        int lat;
        @(negedge clk);
        en[k] = 1'b1; wr[k] = w; ad[k] = a; wd[k] = d;
        #1;
        checkOutput("stall_req", {31'd0, st[k]}, 32'd1);
        @(posedge clk);
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (lat == 1 && drop) begin
                en[k] = 1'b0; wr[k] = 1'b1; ad[k] = 32'h30; wd[k] = 32'hFFFF_0000;
                #1;
                checkOutput("stall_drop", {31'd0, st[k]}, 32'd0);
            end
            if (dn[k]) break;
            if (!drop) checkOutput("stall_busy", {31'd0, st[k]}, 32'd1);
        end
        checkOutput("latency", lat, expLat);
        checkOutput("stall_done", {31'd0, st[k]}, 32'd0);
        rdOut = rd[k];
`ifdef DMEM_ALIGN_CHK_EN
        misOut = mi[k];
`else
        misOut = 1'b0;
`endif
        en[k] = 1'b0; wr[k] = 1'b0;
    endtask

    initial begin
        logic [31:0] r;
        logic        m;
        vecs = 0;
        errs = 0;
        for (int i = 0; i < N_DUT; i++) begin
            en[i] = 1'b0; wr[i] = 1'b0; ad[i] = '0; wd[i] = '0;
        end
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        for (int i = 0; i < N_DUT; i++) begin
            checkOutput("reset_rdata", rd[i], 32'd0);
            checkOutput("reset_done", {31'd0, dn[i]}, 32'd0);
            checkOutput("reset_stall", {31'd0, st[i]}, 32'd0);
        end
        @(negedge clk);
        rst = 1'b1;

        // WAIT_CYCLES=1 store then load
        applyStimulus(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 2, r, m);
        applyStimulus(0, 1'b0, 32'h10, 32'h0, 1'b0, 2, r, m);
        checkOutput("w1_load", r, 32'hDEAD_BEEF);
        @(negedge clk);
        checkOutput("w1_hold_rdata", rd[0], 32'hDEAD_BEEF);
        checkOutput("w1_done_pulse", {31'd0, dn[0]}, 32'd0);
        applyStimulus(0, 1'b1, 32'h14, 32'h0000_0055, 1'b0, 2, r, m);
        checkOutput("store_keeps_rdata", r, 32'hDEAD_BEEF);

        // WAIT_CYCLES=0
        applyStimulus(1, 1'b1, 32'h40, 32'hA5A5_5A5A, 1'b0, 1, r, m);
        applyStimulus(1, 1'b0, 32'h40, 32'h0, 1'b0, 1, r, m);
        checkOutput("w0_load", r, 32'hA5A5_5A5A);

        // address wrap modulo 4*DEPTH_WORDS
        applyStimulus(0, 1'b1, 32'h1000, 32'h1234_5678, 1'b0, 2, r, m);
        applyStimulus(0, 1'b0, 32'h0, 32'h0, 1'b0, 2, r, m);
        checkOutput("wrap_load", r, 32'h1234_5678);
        applyStimulus(0, 1'b0, 32'hFFFF_F000, 32'h0, 1'b0, 2, r, m);
        checkOutput("wrap_high_load", r, 32'h1234_5678);
`ifndef DMEM_ALIGN_CHK_EN
        applyStimulus(0, 1'b0, 32'h13, 32'h0, 1'b0, 2, r, m);
        checkOutput("lowbits_ignored", r, 32'hDEAD_BEEF);
`endif

        // reset while BUSY on a store (WAIT_CYCLES=3)
        applyStimulus(2, 1'b1, 32'h20, 32'h1111_1111, 1'b0, 4, r, m);
        @(negedge clk);
        en[2] = 1'b1; wr[2] = 1'b1; ad[2] = 32'h20; wd[2] = 32'h2222_2222;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rst_busy_done", {31'd0, dn[2]}, 32'd0);
        checkOutput("rst_rdata_clear", rd[0], 32'd0);
        en[2] = 1'b0; wr[2] = 1'b0;
        #1;
        checkOutput("rst_stall", {31'd0, st[2]}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("rst_no_done", {31'd0, dn[2]}, 32'd0);
        end
        applyStimulus(2, 1'b0, 32'h20, 32'h0, 1'b0, 4, r, m);
        checkOutput("rst_store_discarded", r, 32'h1111_1111);

        // request withdrawn mid-BUSY, inputs scrambled after accept
        applyStimulus(2, 1'b1, 32'h30, 32'h3333_3333, 1'b0, 4, r, m);
        applyStimulus(2, 1'b0, 32'h20, 32'h0, 1'b1, 4, r, m);
        checkOutput("drop_load", r, 32'h1111_1111);
        applyStimulus(2, 1'b0, 32'h30, 32'h0, 1'b0, 4, r, m);
        checkOutput("drop_no_store", r, 32'h3333_3333);

`ifdef DMEM_ALIGN_CHK_EN
        applyStimulus(0, 1'b1, 32'h20, 32'hCAFE_F00D, 1'b0, 2, r, m);
        checkOutput("align_store_ok", {31'd0, m}, 32'd0);
        applyStimulus(0, 1'b1, 32'h22, 32'h0BAD_BAD0, 1'b0, 2, r, m);
        checkOutput("align_store_mis", {31'd0, m}, 32'd1);
        @(negedge clk);
        checkOutput("align_mis_idle", {31'd0, mi[0]}, 32'd0);
        applyStimulus(0, 1'b0, 32'h20, 32'h0, 1'b0, 2, r, m);
        checkOutput("align_word_kept", r, 32'hCAFE_F00D);
        checkOutput("align_load_ok", {31'd0, m}, 32'd0);
        applyStimulus(0, 1'b0, 32'h23, 32'h0, 1'b0, 2, r, m);
        checkOutput("align_load_zero", r, 32'd0);
        checkOutput("align_load_mis", {31'd0, m}, 32'd1);
`endif

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
